// File: rtl/mux_rr_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg_pkg
// Shared constants for the registered N-channel multiplexer and its arbiter.
//   mode_e      : selection mode encoding (fixed select / round-robin)
//   next_index  : wrap-around successor of a channel index
// -----------------------------------------------------------------------------
package mux_rr_reg_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Index that follows idx in a ring of n channels.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_rr_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req upward from ptr with
// wrap-around and grants the first requester.
//   req       : per-channel request
//   ptr       : highest-priority channel index
//   en        : arbitration enable; grant is zero when low
//   grant     : one-hot (or zero) grant
//   grant_idx : binary index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx
);

  always_comb begin
    logic          found;
    int            c;
    logic [SELW-1:0] c_idx;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    c_idx     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      c = int'(ptr) + i;
      if (c >= CHANNELS) c = c - CHANNELS;
      c_idx = SELW'(c);
      if (en && !found && req[c_idx]) begin
        grant[c_idx] = 1'b1;
        grant_idx    = c_idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// -----------------------------------------------------------------------------
// mux_rr_reg
// Registered N-channel multiplexer with valid/ready on every input and on the
// output. Selects one channel either by a fixed index (sel) or round-robin,
// and holds the selected word in a one-entry output register with backpressure.
//   clk, reset           : rising-edge clock, async active-high reset
//   mode                 : 0 = fixed select, 1 = round-robin
//   sel                  : channel index used in fixed mode
//   in_valid / in_ready  : per-channel handshake (in_ready one-hot or zero)
//   in_data              : channel k at bits [k*WIDTH +: WIDTH]
//   out_valid / out_ready: output handshake
//   out_data, out_chan   : registered word and the channel it came from
// -----------------------------------------------------------------------------
module mux_rr_reg
  import mux_rr_reg_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_chan_q,  out_chan_d;
  logic [SELW-1:0]     ptr_q,       ptr_d;

  logic                is_rr;
  logic                free;
  logic                xfer;
  logic [CHANNELS-1:0] rr_grant, fixed_grant, grant;
  logic [SELW-1:0]     rr_idx, grant_idx;

  assign is_rr = (mode_e'(mode) == MODE_RR);
  assign free  = !out_valid_q || out_ready;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .en        (is_rr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Fixed mode: sel may exceed CHANNELS-1 when CHANNELS is not a power of two.
  always_comb begin
    fixed_grant = '0;
    if (int'(sel) < CHANNELS && in_valid[sel]) fixed_grant[sel] = 1'b1;
  end

  assign grant     = is_rr ? rr_grant : fixed_grant;
  assign grant_idx = is_rr ? rr_idx   : sel;

  // Reset masks the handshake so no producer sees an accept while held in reset.
  assign in_ready = (free && !reset) ? grant : '0;
  assign xfer     = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      // Reload covers the simultaneous drain case: out_valid stays 1.
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      if (is_rr) ptr_d = SELW'(next_index(int'(grant_idx), CHANNELS));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples the
      // pre-edge value of every other flop, matching the hardware.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. Successor to the fixed 16-bit two-way mux: it generalises data width and channel count, and adds two selection modes, fixed-select and round-robin. It also registers the selected word behind a one-entry output stage with backpressure. It sits between several producers (register-file ports, memory-mapped sources) and a single consumer bus in the CPU datapath.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥1)
- SELW, max(1, $clog2(CHANNELS)), width of channel-index fields (derived; not overridden)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- out_data  output  WIDTH  registered selected word
- out_chan  output  SELW  index of the channel that produced out_data

## Operation
- Output stage holds one entry; `free = !out_valid || out_ready`.
- Grant (combinational, at most one bit set):
  - Fixed mode: grant channel `sel` if `in_valid[sel]` and `sel < CHANNELS`.
  - Round-robin mode: search from `ptr` upward with wrap-around; grant the first valid channel.
- `in_ready = grant & {CHANNELS{free}}`. `in_ready` is all zero while reset is asserted.
- Transfer on channel k: `in_valid[k] && in_ready[k]` at a rising edge. The output register then loads `out_data <= in_data[k]`, `out_chan <= k` and `out_valid <= 1`.
- Output drain: `out_valid && out_ready` with no new transfer gives `out_valid <= 0`.
- Simultaneous drain and transfer: the register reloads and `out_valid` stays 1, so throughput is one word per cycle.
- Round-robin pointer `ptr` (SELW bits):
  - On a transfer from channel k, `ptr <= (k+1) mod CHANNELS`.
  - It is unchanged when there is no transfer, and unchanged in fixed mode.
- Mode or `sel` changes take effect in the same cycle's grant. A word already in the output register is unaffected.
- `in_data` of non-granted channels is ignored. Producers must hold data stable while valid and not ready.
- CHANNELS=1: `ptr` is constantly 0 and both modes behave identically.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`, `in_ready=0`.
- Reset acts immediately, with no clock edge needed. Deassertion is sampled at the next rising edge; the first grant is possible in that cycle.
- Latency: 1 cycle, from transfer edge to `out_valid`/`out_data` visible.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid` and `out_ready`. No combinational path exists from any `in_data` to `out_data`.
- Backpressure: while `out_valid=1` and `out_ready=0`, `out_data`/`out_chan` hold, `in_ready` is all 0 and `ptr` holds.
- Reset mid-stream: the pending output word is discarded, and `ptr` returns to 0.

## Structure
- Mode encodings `MODE_FIXED=1'b0` and `MODE_RR=1'b1` go in the shared CPU constants include, next to the ALU control encodings.
- Sub-module `rr_arbiter`, parametrised by CHANNELS, is natural. It takes `req`, `ptr` and `en` and produces a one-hot `grant` plus its binary index. It is purely combinational and reusable for the memory-port arbiter.
- The top level contains the output register, `ptr`, the mode/fixed-select logic and the data mux (indexed part-select by grant index).

## Test plan
All with WIDTH=16, CHANNELS=4, and `in_data` of channel k = 16'hA000+k unless stated.

1. Reset: assert `reset` asynchronously between clock edges -> `out_valid`, `out_data`, `out_chan` and `in_ready` all 0 immediately.
2. Fixed mode, `sel=2`, all valid, `out_ready=1` -> `in_ready=4'b0100`; from the cycle after, `out_data=16'hA002` and `out_chan=2` every cycle.
3. Round-robin, all valid, `out_ready=1` -> `out_chan` sequence 0,1,2,3,0,1; `out_valid` continuously 1 after the first word.
4. Round-robin with only channels 1 and 3 valid -> `out_chan` alternates 1,3,1,3. Drop channel 3 -> 1,1,1.
5. Backpressure: hold `out_ready=0` for 3 cycles after word 16'hA001 -> `out_data` holds 16'hA001 and `in_ready=0`. Release -> next word is 16'hA002.
6. Reset mid-stream after channel 2 is granted in round-robin -> after release, the first grant with all valid is channel 0, not 3.
